ahb_arbiter: RTL and testbench
==============================

Name: ahb_arbiter

Overview:
- Round-robin AHB bus arbiter that shares the single AHB address/data path among up to four masters.
- Produces one-hot grants, the address-phase master index (hmaster) for the master-side address/control mux, and the data-phase index for the write-data mux.
- Sits beside the slave-select decoder in the AHB interconnect; the arbiter picks the master, the decoder picks the slave.
- Supports locked transfers and a default master when the bus is idle.

Parameters:
- NUM_MASTERS, 4, number of requesting masters (2..4).
- MW, 2, width of master index, equal to clog2(NUM_MASTERS).
- DEFAULT_MASTER, 0, index granted when no master is requesting.

Ports:
- hclk  input  1  bus clock; all state changes on rising edge.
- hreset  input  1  asynchronous, active-high reset.
- hbusreq  input  NUM_MASTERS  bus request per master, bit i = master i.
- hlock  input  NUM_MASTERS  lock request per master, qualified with hbusreq.
- htrans  input  2  transfer type of current owner: 00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ.
- hready  input  1  transfer-complete signal from the slave-side mux.
- hgrant  output  NUM_MASTERS  one-hot grant.
- hmaster  output  MW  index of the master owning the address phase.
- hmaster_data  output  MW  index of the master owning the data phase.
- hmastlock  output  1  current address-phase transfer is locked.

Behaviour:
Reset (asynchronous, hreset=1):
- hgrant = one-hot(DEFAULT_MASTER).
- hmaster = hmaster_data = DEFAULT_MASTER.
- hmastlock = 0.
- Round-robin pointer (last_owner) = DEFAULT_MASTER.
- FSM = ST_IDLE.
- Asserting reset mid-burst aborts immediately; there is no completion handshake.

Registers:
- All outputs are registered.
- The grant decision takes 1 cycle: a request sampled at edge N can raise hgrant after edge N.

FSM states:
- ST_IDLE: the default master holds the grant and no hbusreq bit is set.
- ST_BUS: an owner holds the grant, unlocked.
- ST_LOCK: an owner holds the grant with a lock.

Re-arbitration point:
- Re-arbitrate only on a cycle with hready=1 and htrans in {IDLE, NONSEQ}, and FSM not in ST_LOCK.
- If htrans is BUSY or SEQ, or hready=0, hgrant holds.

Round-robin selection:
- Search requesters starting at last_owner+1, modulo NUM_MASTERS.
- The first set hbusreq bit wins; last_owner is updated to the winner.
- If there are no requests, grant DEFAULT_MASTER and go to ST_IDLE. last_owner is not updated in this case.
- A current owner that still requests does not win again while another master requests, because the pointer starts past it.

Lock handling:
- If the winner has hlock=1, go to ST_LOCK.
- ST_LOCK holds the grant regardless of other requests until hready=1 and hlock[owner]=0 and htrans is IDLE or NONSEQ.
- On that exit condition, re-arbitrate normally on that same cycle.

Handover:
- hmaster <= index(hgrant) on every cycle with hready=1; it holds when hready=0.
- hmaster_data <= hmaster on every cycle with hready=1.
- hmastlock <= hlock[index(hgrant)] on every cycle with hready=1.

Invariants and boundary conditions:
- hgrant is never zero and never multi-hot, including from reset.
- Simultaneous requests from all masters are served in strict order i+1, i+2, …
- A request dropped before grant is ignored: no sticky state.
- Request bits at index NUM_MASTERS and above do not exist. When NUM_MASTERS=2, MW=1.

Decomposition:
- Shared package ahb_pkg holds:
  - HTRANS_IDLE/BUSY/NONSEQ/SEQ constants;
  - FSM state encodings ST_IDLE/ST_BUS/ST_LOCK;
  - a one-hot-to-index function reused by the interconnect muxes.
- One natural sub-module: rr_pick, a combinational round-robin priority selector (inputs: req vector, last_owner; outputs: winner index, any_req).

Test Plan:
1. Reset with hbusreq=0000, hready=1 -> hgrant=0001, hmaster=0, hmastlock=0, state ST_IDLE; after release with no requests, values unchanged for 10 cycles.
2. hbusreq=0100, htrans=IDLE, hready=1 -> next cycle hgrant=0100; cycle after, hmaster=2; one hready later, hmaster_data=2.
3. hbusreq=1111 held, master drives NONSEQ then IDLE each transfer, hready=1 -> grant order 0010, 0100, 1000, 0001, 0010 (starting with last_owner=0).
4. Master 1 granted, htrans=SEQ for 4 cycles with hbusreq=1111 -> hgrant stays 0010 throughout; it moves to 0100 only after htrans=IDLE with hready=1.
5. Master 3 requests with hlock=1 and is granted -> hmastlock=1; other requests ignored for 6 cycles; hlock drops with htrans=IDLE -> next grant 0001; hmastlock returns to 0.
6. hready=0 for 3 cycles while hbusreq changes 0001->0100 -> hgrant, hmaster and hmaster_data all frozen; hreset pulsed mid-freeze -> hgrant=0001 immediately, hmaster=0.

Source files
------------

// File: rtl/ahb_pkg.sv
// Shared AHB interconnect definitions: transfer types, arbiter states and
// a one-hot to index helper used by the arbiter and the master-side muxes.
package ahb_pkg;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_BUSY   = 2'b01;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HTRANS_SEQ    = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUS  = 2'd1,
      ST_LOCK = 2'd2
   } arb_state_t;

   // Callers zero-extend narrower grant vectors to four bits.
   function automatic logic [1:0] onehot_to_idx(input logic [3:0] oh);
      logic [1:0] idx;
      idx = 2'd0;
      for (int i = 0; i < 4; i++) begin
         if (oh[i]) idx = 2'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/ahb_arbiter_rr_pick.sv
// Combinational round-robin selector: first set request after last_owner wins.
// Zero latency; any_req low means winner is meaningless.
module rr_pick #(
   parameter int NUM_MASTERS = 4,
   parameter int MW          = 2
) (
   input  logic [NUM_MASTERS-1:0] req,
   input  logic [MW-1:0]          last_owner,
   output logic [MW-1:0]          winner,
   output logic                   any_req
);

   always_comb begin
      logic found;
      int   idx;
      winner = '0;
      found  = 1'b0;
      idx    = 0;
      // The scan ends on last_owner itself, so it only wins when alone.
      for (int k = 1; k <= NUM_MASTERS; k++) begin
         idx = (int'(last_owner) + k) % NUM_MASTERS;
         if (!found && req[idx]) begin
            winner = idx[MW-1:0];
            found  = 1'b1;
         end
      end
      any_req = |req;
   end

endmodule

// File: rtl/ahb_arbiter.sv
// Round-robin AHB arbiter with locked transfers and an idle default master.
// Grant registered one cycle after the request; grant and handover hold while hready=0.
module ahb_arbiter #(
   parameter int NUM_MASTERS    = 4,
   parameter int MW             = 2,
   parameter int DEFAULT_MASTER = 0
) (
   input  logic                   hclk,
   input  logic                   hreset,
   input  logic [NUM_MASTERS-1:0] hbusreq,
   input  logic [NUM_MASTERS-1:0] hlock,
   input  logic [1:0]             htrans,
   input  logic                   hready,
   output logic [NUM_MASTERS-1:0] hgrant,
   output logic [MW-1:0]          hmaster,
   output logic [MW-1:0]          hmaster_data,
   output logic                   hmastlock
);
   import ahb_pkg::*;

   localparam logic [NUM_MASTERS-1:0] DEF_GRANT =
      {{(NUM_MASTERS-1){1'b0}}, 1'b1} << DEFAULT_MASTER;
   localparam logic [MW-1:0] DEF_IDX = MW'(DEFAULT_MASTER);

   arb_state_t             state;
   logic [MW-1:0]          last_owner;
   logic [MW-1:0]          owner;
   logic [MW-1:0]          winner;
   logic                   any_req;
   logic [NUM_MASTERS-1:0] win_oh;
   logic                   rearb_ok;
   logic                   do_arb;

   rr_pick #(.NUM_MASTERS(NUM_MASTERS), .MW(MW)) u_pick (
      .req        (hbusreq),
      .last_owner (last_owner),
      .winner     (winner),
      .any_req    (any_req)
   );

   always_comb begin
      logic [3:0] grant_ext;
      logic [1:0] owner_full;
      grant_ext                    = 4'd0;
      grant_ext[NUM_MASTERS-1:0]   = hgrant;
      owner_full                   = onehot_to_idx(grant_ext);
      owner                        = owner_full[MW-1:0];
      win_oh                       = '0;
      win_oh[winner]               = 1'b1;
   end

   // Bursts (BUSY/SEQ) and wait states never re-arbitrate; a lock also
   // blocks until its owner releases hlock at a transfer boundary.
   assign rearb_ok = hready && (htrans == HTRANS_IDLE || htrans == HTRANS_NONSEQ);
   assign do_arb   = rearb_ok && (state != ST_LOCK || !hlock[owner]);

   always_ff @(posedge hclk or posedge hreset) begin
      if (hreset) begin
         state        <= ST_IDLE;
         last_owner   <= DEF_IDX;
         hgrant       <= DEF_GRANT;
         hmaster      <= DEF_IDX;
         hmaster_data <= DEF_IDX;
         hmastlock    <= 1'b0;
      end else begin
         if (do_arb) begin
            if (any_req) begin
               hgrant     <= win_oh;
               last_owner <= winner;
               state      <= (hlock[winner] && hbusreq[winner]) ? ST_LOCK : ST_BUS;
            end else begin
               hgrant <= DEF_GRANT;
               state  <= ST_IDLE;
            end
         end
         if (hready) begin
            hmaster      <= owner;
            hmaster_data <= hmaster;
            hmastlock    <= hlock[owner];
         end
      end
   end

endmodule

// File: tb/tb_ahb_arbiter.sv
// Directed vector bench for ahb_arbiter: table of per-cycle inputs and
// expected registered outputs, plus hand sequences for reset and wait states.
module tb_ahb_arbiter;

   logic       hclk;
   logic       hreset;
   logic [3:0] hbusreq;
   logic [3:0] hlock;
   logic [1:0] htrans;
   logic       hready;
   logic [3:0] hgrant;
   logic [1:0] hmaster;
   logic [1:0] hmaster_data;
   logic       hmastlock;

   int checks;
   int failures;

   ahb_arbiter #(.NUM_MASTERS(4), .MW(2), .DEFAULT_MASTER(0)) dut (
      .hclk         (hclk),
      .hreset       (hreset),
      .hbusreq      (hbusreq),
      .hlock        (hlock),
      .htrans       (htrans),
      .hready       (hready),
      .hgrant       (hgrant),
      .hmaster      (hmaster),
      .hmaster_data (hmaster_data),
      .hmastlock    (hmastlock)
   );

   initial hclk = 1'b0;
   always #5 hclk = ~hclk;

   typedef struct packed {
      logic [3:0] req;
      logic [3:0] lock;
      logic [1:0] tr;
      logic       rdy;
      logic [3:0] g;
      logic [1:0] m;
      logic [1:0] d;
      logic       l;
   } vec_t;

   localparam logic [1:0] T_IDLE = 2'b00;
   localparam logic [1:0] T_BUSY = 2'b01;
   localparam logic [1:0] T_NSEQ = 2'b10;
   localparam logic [1:0] T_SEQ  = 2'b11;

   vec_t tbl[26];

   function automatic vec_t mk(input logic [3:0] req, input logic [3:0] lock,
                               input logic [1:0] tr, input logic rdy,
                               input logic [3:0] g, input logic [1:0] m,
                               input logic [1:0] d, input logic l);
      vec_t v;
      v.req = req; v.lock = lock; v.tr = tr; v.rdy = rdy;
      v.g = g; v.m = m; v.d = d; v.l = l;
      return v;
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk_all(input string tag, input logic [3:0] g, input logic [1:0] m,
                          input logic [1:0] d, input logic l);
      chk({tag, ".hgrant"},       int'(hgrant),       int'(g));
      chk({tag, ".hmaster"},      int'(hmaster),      int'(m));
      chk({tag, ".hmaster_data"}, int'(hmaster_data), int'(d));
      chk({tag, ".hmastlock"},    int'(hmastlock),    int'(l));
   endtask

   task automatic tick();
      @(posedge hclk);
      #1;
   endtask

   initial begin
      checks   = 0;
      failures = 0;

      //           req      lock     tr      rdy   grant    hm    hmd   lock
      // single request from master 2, then pipeline through hmaster/hmaster_data
      tbl[0]  = mk(4'b0100, 4'b0000, T_IDLE, 1'b1, 4'b0100, 2'd0, 2'd0, 1'b0);
      tbl[1]  = mk(4'b0100, 4'b0000, T_NSEQ, 1'b1, 4'b0100, 2'd2, 2'd0, 1'b0);
      tbl[2]  = mk(4'b0100, 4'b0000, T_SEQ,  1'b1, 4'b0100, 2'd2, 2'd2, 1'b0);
      // park pointer at master 0, then all four request
      tbl[3]  = mk(4'b0001, 4'b0000, T_IDLE, 1'b1, 4'b0001, 2'd2, 2'd2, 1'b0);
      tbl[4]  = mk(4'b1111, 4'b0000, T_NSEQ, 1'b1, 4'b0010, 2'd0, 2'd2, 1'b0);
      tbl[5]  = mk(4'b1111, 4'b0000, T_IDLE, 1'b1, 4'b0100, 2'd1, 2'd0, 1'b0);
      tbl[6]  = mk(4'b1111, 4'b0000, T_NSEQ, 1'b1, 4'b1000, 2'd2, 2'd1, 1'b0);
      tbl[7]  = mk(4'b1111, 4'b0000, T_IDLE, 1'b1, 4'b0001, 2'd3, 2'd2, 1'b0);
      tbl[8]  = mk(4'b1111, 4'b0000, T_NSEQ, 1'b1, 4'b0010, 2'd0, 2'd3, 1'b0);
      // master 1 bursts: SEQ and BUSY hold the grant
      tbl[9]  = mk(4'b1111, 4'b0000, T_SEQ,  1'b1, 4'b0010, 2'd1, 2'd0, 1'b0);
      tbl[10] = mk(4'b1111, 4'b0000, T_SEQ,  1'b1, 4'b0010, 2'd1, 2'd1, 1'b0);
      tbl[11] = mk(4'b1111, 4'b0000, T_SEQ,  1'b1, 4'b0010, 2'd1, 2'd1, 1'b0);
      tbl[12] = mk(4'b1111, 4'b0000, T_SEQ,  1'b1, 4'b0010, 2'd1, 2'd1, 1'b0);
      tbl[13] = mk(4'b1111, 4'b0000, T_IDLE, 1'b1, 4'b0100, 2'd1, 2'd1, 1'b0);
      tbl[14] = mk(4'b1111, 4'b0000, T_BUSY, 1'b1, 4'b0100, 2'd2, 2'd1, 1'b0);
      // locked transfer from master 3 shuts out the others
      tbl[15] = mk(4'b1000, 4'b1000, T_IDLE, 1'b1, 4'b1000, 2'd2, 2'd2, 1'b0);
      tbl[16] = mk(4'b1111, 4'b1000, T_NSEQ, 1'b1, 4'b1000, 2'd3, 2'd2, 1'b1);
      tbl[17] = mk(4'b1111, 4'b1000, T_IDLE, 1'b1, 4'b1000, 2'd3, 2'd3, 1'b1);
      tbl[18] = mk(4'b1111, 4'b1000, T_SEQ,  1'b1, 4'b1000, 2'd3, 2'd3, 1'b1);
      tbl[19] = mk(4'b1111, 4'b1000, T_IDLE, 1'b1, 4'b1000, 2'd3, 2'd3, 1'b1);
      tbl[20] = mk(4'b1111, 4'b1000, T_NSEQ, 1'b1, 4'b1000, 2'd3, 2'd3, 1'b1);
      // lock released during a wait state: nothing moves until hready
      tbl[21] = mk(4'b1111, 4'b0000, T_IDLE, 1'b0, 4'b1000, 2'd3, 2'd3, 1'b1);
      tbl[22] = mk(4'b1111, 4'b0000, T_IDLE, 1'b1, 4'b0001, 2'd3, 2'd3, 1'b0);
      tbl[23] = mk(4'b0000, 4'b0000, T_IDLE, 1'b1, 4'b0001, 2'd0, 2'd3, 1'b0);
      // request raised only during a wait state is forgotten
      tbl[24] = mk(4'b0100, 4'b0000, T_IDLE, 1'b0, 4'b0001, 2'd0, 2'd3, 1'b0);
      tbl[25] = mk(4'b0000, 4'b0000, T_IDLE, 1'b1, 4'b0001, 2'd0, 2'd0, 1'b0);

      hreset  = 1'b1;
      hbusreq = 4'b0000;
      hlock   = 4'b0000;
      htrans  = T_IDLE;
      hready  = 1'b1;
      #2;
      chk_all("reset_async", 4'b0001, 2'd0, 2'd0, 1'b0);
      tick();
      tick();
      chk_all("reset_held", 4'b0001, 2'd0, 2'd0, 1'b0);
      hreset = 1'b0;

      for (int i = 0; i < 10; i++) begin
         tick();
         chk("idle_hgrant", int'(hgrant), 1);
         chk("idle_hmaster", int'(hmaster), 0);
      end

      for (int i = 0; i < 26; i++) begin
         hbusreq = tbl[i].req;
         hlock   = tbl[i].lock;
         htrans  = tbl[i].tr;
         hready  = tbl[i].rdy;
         tick();
         chk_all($sformatf("vec%0d", i), tbl[i].g, tbl[i].m, tbl[i].d, tbl[i].l);
      end

      // grant master 1, then freeze with hready=0 while requests change
      hbusreq = 4'b0010; htrans = T_IDLE; hready = 1'b1;
      tick();
      chk_all("frz_setup0", 4'b0010, 2'd0, 2'd0, 1'b0);
      htrans = T_NSEQ;
      tick();
      chk_all("frz_setup1", 4'b0010, 2'd1, 2'd0, 1'b0);
      hready = 1'b0; htrans = T_IDLE; hbusreq = 4'b0001;
      tick();
      chk_all("frz0", 4'b0010, 2'd1, 2'd0, 1'b0);
      hbusreq = 4'b0100;
      tick();
      chk_all("frz1", 4'b0010, 2'd1, 2'd0, 1'b0);
      hreset = 1'b1;
      #1;
      chk_all("frz_reset", 4'b0001, 2'd0, 2'd0, 1'b0);
      tick();
      hreset = 1'b0;
      hbusreq = 4'b0000; hready = 1'b1;
      tick();
      chk_all("post_reset", 4'b0001, 2'd0, 2'd0, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
